// File: rtl/race_pkg.sv
// Shared race definitions: FSM state and winner codes plus default widths,
// reused by race_ctl and by the draw stages.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    RACE      = 2'b10,
    FINISH    = 2'b11
  } race_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } race_winner_e;

  localparam int RACE_POS_W     = 16;
  localparam int RACE_SPD_W     = 8;
  localparam int RACE_TRACK_LEN = 4000;

endpackage

// File: rtl/race_ctl_if.sv
// Key inputs and game-state outputs between kb_interface, race_ctl and the
// draw pipeline; master drives keys/tick, slave is the race controller.
interface race_ctl_if
  import race_pkg::*;
#(
  parameter int POS_W = RACE_POS_W,
  parameter int SPD_W = RACE_SPD_W
);

  logic             tick;
  logic             key_start;
  logic             key_p1;
  logic             key_p2;
  logic [POS_W-1:0] pos_p1;
  logic [POS_W-1:0] pos_p2;
  logic [SPD_W-1:0] speed_p1;
  logic [SPD_W-1:0] speed_p2;
  logic [1:0]       lights;
  logic             go;
  logic [1:0]       state;
  logic [1:0]       winner;

  modport master (
    output tick, key_start, key_p1, key_p2,
    input  pos_p1, pos_p2, speed_p1, speed_p2, lights, go, state, winner
  );

  modport slave (
    input  tick, key_start, key_p1, key_p2,
    output pos_p1, pos_p2, speed_p1, speed_p2, lights, go, state, winner
  );

endinterface

// File: rtl/race_player.sv
// One player's throttle: key tap detection plus saturating speed/position update.
// The tap output exists only when RACE_CTL_FALSE_START_EN is defined.
module race_player
  import race_pkg::*;
#(
  parameter int POS_W     = RACE_POS_W,
  parameter int SPD_W     = RACE_SPD_W,
  parameter int ACCEL     = 4,
  parameter int DRAG      = 1,
  parameter int MAX_SPEED = 63,
  parameter int TRACK_LEN = RACE_TRACK_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             key,
  input  logic             run,
  input  logic             clear,
  input  logic             stop,
  output logic [POS_W-1:0] pos,
  output logic [SPD_W-1:0] speed,
`ifdef RACE_CTL_FALSE_START_EN
  output logic             tap,
`endif
  output logic             at_finish
);

  localparam logic [POS_W:0]   LIMIT = (POS_W+1)'(TRACK_LEN);
  localparam logic [SPD_W+1:0] ACC_V = (SPD_W+2)'(ACCEL);
  localparam logic [SPD_W+1:0] DRG_V = (SPD_W+2)'(DRAG);
  localparam logic [SPD_W+1:0] MAX_V = (SPD_W+2)'(MAX_SPEED);

  logic             r_prev;
  logic             r_armed;
  logic [POS_W-1:0] r_pos;
  logic [SPD_W-1:0] r_speed;
  logic             w_tap;
  logic [POS_W:0]   w_pos_sum;
  logic [POS_W-1:0] w_pos_next;
  logic [SPD_W+1:0] w_spd_sum;
  logic [SPD_W-1:0] w_spd_next;

  // r_armed masks the first cycle after reset so a key held through release never taps
  assign w_tap      = key & ~r_prev & r_armed;
  assign w_pos_sum  = {1'b0, r_pos} + (POS_W+1)'(r_speed);
  assign w_pos_next = (w_pos_sum >= LIMIT) ? LIMIT[POS_W-1:0] : w_pos_sum[POS_W-1:0];
  assign w_spd_sum  = {2'b00, r_speed} + (w_tap ? ACC_V : '0) - (tick ? DRG_V : '0);

  // MSB of the widened sum acts as the sign, so one clamp covers both ends
  always_comb begin
    w_spd_next = w_spd_sum[SPD_W-1:0];
    if (w_spd_sum[SPD_W+1]) begin
      w_spd_next = '0;
    end else if (w_spd_sum > MAX_V) begin
      w_spd_next = MAX_V[SPD_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pos   <= '0;
      r_speed <= '0;
    end else begin
      r_prev  <= key;
      r_armed <= 1'b1;
      if (clear) begin
        r_pos   <= '0;
        r_speed <= '0;
      end else if (run) begin
        if (tick) begin
          r_pos <= w_pos_next;
        end
        r_speed <= stop ? '0 : w_spd_next;
      end
    end
  end

  assign pos       = r_pos;
  assign speed     = r_speed;
  assign at_finish = run & tick & (w_pos_next == LIMIT[POS_W-1:0]);
`ifdef RACE_CTL_FALSE_START_EN
  assign tap       = w_tap;
`endif

endmodule

// File: rtl/race_ctl.sv
// Race game controller: start-light countdown, two player movers and winner detection.
// Optional false-start detection during countdown: RACE_CTL_FALSE_START_EN.
module race_ctl
  import race_pkg::*;
#(
  parameter int POS_W          = RACE_POS_W,
  parameter int SPD_W          = RACE_SPD_W,
  parameter int TICK_PER_LIGHT = 10,
  parameter int ACCEL          = 4,
  parameter int DRAG           = 1,
  parameter int MAX_SPEED      = 63,
  parameter int TRACK_LEN      = RACE_TRACK_LEN
) (
  input  logic       clk,
  input  logic       reset,
  race_ctl_if.slave  bus
);

  localparam int              CNT_W    = $clog2(TICK_PER_LIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PER_LIGHT - 1);

  race_state_e      r_state, w_state_nxt;
  race_winner_e     r_winner, w_winner_nxt;
  logic [1:0]       r_lights, w_lights_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_go, w_go_nxt;
  logic             r_start_prev;
  logic             r_start_armed;
  logic             w_start_tap;
  logic             w_enter;
  logic             w_run;
  logic             w_fin1, w_fin2;
`ifdef RACE_CTL_FALSE_START_EN
  logic             w_tap1, w_tap2;
`endif

  assign w_start_tap = bus.key_start & ~r_start_prev & r_start_armed;
  assign w_run       = (r_state == RACE);

  race_player #(
    .POS_W(POS_W), .SPD_W(SPD_W), .ACCEL(ACCEL), .DRAG(DRAG),
    .MAX_SPEED(MAX_SPEED), .TRACK_LEN(TRACK_LEN)
  ) u_p1 (
    .clk(clk), .reset(reset), .tick(bus.tick), .key(bus.key_p1),
    .run(w_run), .clear(w_enter), .stop(w_fin1 | w_fin2),
    .pos(bus.pos_p1), .speed(bus.speed_p1),
`ifdef RACE_CTL_FALSE_START_EN
    .tap(w_tap1),
`endif
    .at_finish(w_fin1)
  );

  race_player #(
    .POS_W(POS_W), .SPD_W(SPD_W), .ACCEL(ACCEL), .DRAG(DRAG),
    .MAX_SPEED(MAX_SPEED), .TRACK_LEN(TRACK_LEN)
  ) u_p2 (
    .clk(clk), .reset(reset), .tick(bus.tick), .key(bus.key_p2),
    .run(w_run), .clear(w_enter), .stop(w_fin1 | w_fin2),
    .pos(bus.pos_p2), .speed(bus.speed_p2),
`ifdef RACE_CTL_FALSE_START_EN
    .tap(w_tap2),
`endif
    .at_finish(w_fin2)
  );

  // Winner codes are one bit per player, so finish/false-start flags map straight onto them
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_lights_nxt = r_lights;
    w_cnt_nxt    = r_cnt;
    w_go_nxt     = r_go;
    w_enter      = 1'b0;
    case (r_state)
      IDLE, FINISH: begin
        if (w_start_tap) begin
          w_state_nxt  = COUNTDOWN;
          w_winner_nxt = WIN_NONE;
          w_lights_nxt = 2'd1;
          w_cnt_nxt    = '0;
          w_go_nxt     = 1'b0;
          w_enter      = 1'b1;
        end
      end
      COUNTDOWN: begin
`ifdef RACE_CTL_FALSE_START_EN
        if (w_tap1 | w_tap2) begin
          w_state_nxt  = FINISH;
          w_winner_nxt = race_winner_e'({w_tap1, w_tap2});
          w_lights_nxt = 2'd0;
        end else
`endif
        if (bus.tick) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (r_lights == 2'd3) begin
              w_state_nxt  = RACE;
              w_lights_nxt = 2'd0;
              w_go_nxt     = 1'b1;
            end else begin
              w_lights_nxt = r_lights + 2'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      RACE: begin
        if (w_fin1 | w_fin2) begin
          w_state_nxt  = FINISH;
          w_winner_nxt = race_winner_e'({w_fin2, w_fin1});
          w_go_nxt     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_winner      <= WIN_NONE;
      r_lights      <= 2'd0;
      r_cnt         <= '0;
      r_go          <= 1'b0;
      r_start_prev  <= 1'b0;
      r_start_armed <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_winner      <= w_winner_nxt;
      r_lights      <= w_lights_nxt;
      r_cnt         <= w_cnt_nxt;
      r_go          <= w_go_nxt;
      r_start_prev  <= bus.key_start;
      r_start_armed <= 1'b1;
    end
  end

  assign bus.state  = r_state;
  assign bus.winner = r_winner;
  assign bus.lights = r_lights;
  assign bus.go     = r_go;

endmodule

// File: tb/tb_race_ctl.sv
// Bench for race_ctl: directed race scenarios plus random play compared with a
// reference model built from the game rules; honours RACE_CTL_FALSE_START_EN.
module tb_race_ctl;

  localparam int TPL    = 10;
  localparam int TL     = 100;
  localparam int MAXS   = 63;
  localparam int M_IDLE = 0;
  localparam int M_CD   = 1;
  localparam int M_RACE = 2;
  localparam int M_FIN  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks  = 0;
  int errors  = 0;

  int mMode, mTicks, mWin;
  int mPos[2];
  int mSpd[2];
  bit mPrevS, mPrev1, mPrev2, mArmed;

  race_ctl_if bus ();

  race_ctl #(.TICK_PER_LIGHT(TPL), .TRACK_LEN(TL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mMode = M_IDLE; mTicks = 0; mWin = 0;
    mPos = '{0, 0}; mSpd = '{0, 0};
    mPrevS = 0; mPrev1 = 0; mPrev2 = 0; mArmed = 0;
  endtask

  // Game rules: lights derive from ticks since start; movement in plain integers
  task automatic modelStep(input bit t, input bit ks, input bit k1, input bit k2);
    bit tapS;
    bit tp[2];
    bit fin[2];
    int np, ns;
    tapS  = mArmed && ks && !mPrevS;
    tp[0] = mArmed && k1 && !mPrev1;
    tp[1] = mArmed && k2 && !mPrev2;
    mPrevS = ks; mPrev1 = k1; mPrev2 = k2; mArmed = 1;
    fin = '{0, 0};
    case (mMode)
      M_IDLE, M_FIN: begin
        if (tapS) begin
          mMode = M_CD; mTicks = 0; mWin = 0;
          mPos = '{0, 0}; mSpd = '{0, 0};
        end
      end
      M_CD: begin
`ifdef RACE_CTL_FALSE_START_EN
        if (tp[0] || tp[1]) begin
          mMode = M_FIN;
          mWin  = (tp[0] ? 2 : 0) + (tp[1] ? 1 : 0);
        end else
`endif
        if (t) begin
          mTicks++;
          if (mTicks == 3 * TPL) mMode = M_RACE;
        end
      end
      M_RACE: begin
        for (int i = 0; i < 2; i++) begin
          np = t ? mPos[i] + mSpd[i] : mPos[i];
          if (np > TL) np = TL;
          ns = mSpd[i] + (tp[i] ? 4 : 0) - (t ? 1 : 0);
          if (ns < 0) ns = 0;
          if (ns > MAXS) ns = MAXS;
          mPos[i] = np; mSpd[i] = ns;
          fin[i] = (np == TL);
        end
        if (fin[0] || fin[1]) begin
          mMode = M_FIN;
          mWin  = (fin[0] ? 1 : 0) + (fin[1] ? 2 : 0);
          mSpd  = '{0, 0};
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input bit t, input bit ks, input bit k1, input bit k2);
    bus.tick = t; bus.key_start = ks; bus.key_p1 = k1; bus.key_p2 = k2;
    @(posedge clk);
    #1;
    modelStep(t, ks, k1, k2);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
  endtask

  task automatic tapKeys(input bit ks, input bit k1, input bit k2, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, ks, k1, k2);
      applyStimulus(0, 0, 0, 0);
    end
  endtask

  task automatic startRace();
    logic [6:0] obs;
    tapKeys(1, 0, 0, 1);
    runTicks(3 * TPL);
    obs = {bus.state, bus.lights, bus.go, bus.winner};
    checks++;
    if (obs !== 7'b10_00_1_00) begin
      errors++;
      $display("[TB] FAIL start_race state/lights/go/winner got %b expected %b", obs, 7'b10_00_1_00);
    end
  endtask

  task automatic test_reset();
    logic [54:0] obs;
    bus.tick = 0; bus.key_start = 1; bus.key_p1 = 0; bus.key_p2 = 0;
    reset = 1;
    #2;
    obs = {bus.state, bus.lights, bus.go, bus.winner, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2};
    checks++;
    if (obs !== 55'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got %h expected 0", obs);
    end
    @(posedge clk);
    #1;
    reset = 0;
    modelReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    checks++;
    if (bus.state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL held_start_at_release state got %0d expected 0", bus.state);
    end
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic test_countdown();
    logic [6:0] obs;
    applyStimulus(0, 1, 0, 0);
    obs = {bus.state, bus.lights, bus.go, bus.winner};
    checks++;
    if (obs !== 7'b01_01_0_00) begin
      errors++;
      $display("[TB] FAIL cd_entry got %b expected %b", obs, 7'b01_01_0_00);
    end
    applyStimulus(0, 0, 0, 0);
    runTicks(TPL - 1);
    checks++;
    if (bus.lights !== 2'd1) begin
      errors++;
      $display("[TB] FAIL cd_lights_9 got %0d expected 1", bus.lights);
    end
    runTicks(1);
    checks++;
    if (bus.lights !== 2'd2) begin
      errors++;
      $display("[TB] FAIL cd_lights_10 got %0d expected 2", bus.lights);
    end
    tapKeys(0, 0, 1, 1);
    obs = {bus.state, bus.lights, bus.go, bus.winner};
`ifdef RACE_CTL_FALSE_START_EN
    checks++;
    if (obs !== 7'b11_00_0_01) begin
      errors++;
      $display("[TB] FAIL false_start_p2 got %b expected %b", obs, 7'b11_00_0_01);
    end
    tapKeys(1, 0, 0, 1);
    runTicks(2 * TPL);
`else
    checks++;
    if (obs !== 7'b01_10_0_00) begin
      errors++;
      $display("[TB] FAIL cd_p2_ignored got %b expected %b", obs, 7'b01_10_0_00);
    end
    runTicks(TPL);
`endif
    checks++;
    if (bus.lights !== 2'd3 || bus.state !== 2'd1) begin
      errors++;
      $display("[TB] FAIL cd_lights_20 got lights %0d state %0d expected 3/1", bus.lights, bus.state);
    end
    runTicks(TPL - 1);
    checks++;
    if (bus.state !== 2'd1 || bus.go !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cd_29 got state %0d go %0d expected 1/0", bus.state, bus.go);
    end
    runTicks(1);
    obs = {bus.state, bus.lights, bus.go, bus.winner};
    checks++;
    if (obs !== 7'b10_00_1_00) begin
      errors++;
      $display("[TB] FAIL cd_to_race got %b expected %b", obs, 7'b10_00_1_00);
    end
  endtask

  task automatic test_accel();
    tapKeys(0, 1, 0, 3);
    checks++;
    if (bus.speed_p1 !== 8'd12 || bus.pos_p1 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL accel_3taps got speed %0d pos %0d expected 12/0", bus.speed_p1, bus.pos_p1);
    end
    applyStimulus(1, 0, 0, 0);
    checks++;
    if ({bus.pos_p1, bus.speed_p1, bus.pos_p2, bus.speed_p2} !== {16'd12, 8'd11, 16'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL accel_tick got p1 %0d/%0d p2 %0d/%0d expected 12/11 0/0",
               bus.pos_p1, bus.speed_p1, bus.pos_p2, bus.speed_p2);
    end
  endtask

  task automatic test_saturate();
    tapKeys(0, 1, 0, 20);
    checks++;
    if (bus.speed_p1 !== 8'd63) begin
      errors++;
      $display("[TB] FAIL speed_ceiling got %0d expected 63", bus.speed_p1);
    end
    applyStimulus(1, 0, 0, 1);
    checks++;
    if ({bus.pos_p2, bus.speed_p2, bus.pos_p1, bus.speed_p1} !== {16'd0, 8'd3, 16'd75, 8'd62}) begin
      errors++;
      $display("[TB] FAIL tap_and_tick got p2 %0d/%0d p1 %0d/%0d expected 0/3 75/62",
               bus.pos_p2, bus.speed_p2, bus.pos_p1, bus.speed_p1);
    end
    applyStimulus(1, 0, 0, 0);
    checks++;
    if ({bus.state, bus.go, bus.winner, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2} !==
        {2'd3, 1'b0, 2'd1, 16'd100, 16'd3, 8'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL p1_wins got state %0d go %0d win %0d pos %0d/%0d spd %0d/%0d expected 3 0 1 100/3 0/0",
               bus.state, bus.go, bus.winner, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2);
    end
  endtask

  task automatic test_finish_clamp();
    startRace();
    tapKeys(0, 1, 0, 16);
    applyStimulus(1, 0, 0, 0);
    checks++;
    if (bus.pos_p1 !== 16'd63 || bus.speed_p1 !== 8'd62) begin
      errors++;
      $display("[TB] FAIL clamp_first_tick got pos %0d speed %0d expected 63/62", bus.pos_p1, bus.speed_p1);
    end
    applyStimulus(1, 0, 0, 0);
    checks++;
    if ({bus.pos_p1, bus.winner, bus.state, bus.speed_p1} !== {16'd100, 2'd1, 2'd3, 8'd0}) begin
      errors++;
      $display("[TB] FAIL clamp_finish got pos %0d win %0d state %0d speed %0d expected 100 1 3 0",
               bus.pos_p1, bus.winner, bus.state, bus.speed_p1);
    end
    tapKeys(0, 0, 1, 3);
    runTicks(2);
    checks++;
    if ({bus.winner, bus.state, bus.pos_p2, bus.pos_p1} !== {2'd1, 2'd3, 16'd0, 16'd100}) begin
      errors++;
      $display("[TB] FAIL finish_hold got win %0d state %0d pos %0d/%0d expected 1 3 0/100",
               bus.winner, bus.state, bus.pos_p2, bus.pos_p1);
    end
  endtask

  task automatic test_tie();
    int used = 0;
    startRace();
    tapKeys(0, 1, 1, 4);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0);
      used++;
      if (bus.state == 2'd3) break;
    end
    checks++;
    if ({bus.winner, bus.pos_p1, bus.pos_p2} !== {2'd3, 16'd100, 16'd100} || used != 8) begin
      errors++;
      $display("[TB] FAIL tie got win %0d pos %0d/%0d after %0d ticks expected 3 100/100 after 8",
               bus.winner, bus.pos_p1, bus.pos_p2, used);
    end
    applyStimulus(0, 1, 0, 0);
    checks++;
    if ({bus.state, bus.lights, bus.winner, bus.pos_p1, bus.pos_p2} !== {2'd1, 2'd1, 2'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL restart got state %0d lights %0d win %0d pos %0d/%0d expected 1 1 0 0/0",
               bus.state, bus.lights, bus.winner, bus.pos_p1, bus.pos_p2);
    end
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [54:0] obs, exp;
    bit t, ks, k1, k2;
    int expLights;
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        bus.key_p1 = 1'($urandom_range(0, 1));
        bus.key_p2 = 1'($urandom_range(0, 1));
        reset = 1;
        #2;
        obs = {bus.state, bus.lights, bus.go, bus.winner, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2};
        checks++;
        if (obs !== 55'd0) begin
          errors++;
          $display("[TB] FAIL midrun_reset got %h expected 0", obs);
        end
        @(posedge clk);
        #1;
        reset = 0;
        modelReset();
      end
      t  = 1'($urandom_range(0, 1));
      ks = ($urandom_range(0, 7) == 0);
      k1 = 1'($urandom_range(0, 1));
      k2 = 1'($urandom_range(0, 1));
      applyStimulus(t, ks, k1, k2);
      expLights = (mMode == M_CD) ? 1 + mTicks / TPL : 0;
      exp = {2'(mMode), 2'(expLights), (mMode == M_RACE), 2'(mWin),
             16'(mPos[0]), 16'(mPos[1]), 8'(mSpd[0]), 8'(mSpd[1])};
      obs = {bus.state, bus.lights, bus.go, bus.winner, bus.pos_p1, bus.pos_p2, bus.speed_p1, bus.speed_p2};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d got %h expected %h", n, obs, exp);
      end
    end
  endtask

  initial begin
    bus.tick = 0; bus.key_start = 0; bus.key_p1 = 0; bus.key_p2 = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_countdown();
    test_accel();
    test_saturate();
    test_finish_clamp();
    test_tie();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_ctl.md
Name: race_ctl

Overview:
Game-control stage sitting between kb_interface and the draw pipeline (draw_background, draw_start, draw_car).
- Turns per-player key taps into speed and track position for both players.
- Sequences the start-light countdown and detects the winner.
- All outputs are registered in the 65 MHz pixel clock domain.
- Movement advances only on a one-cycle tick enable (e.g. a frame or 10 Hz strobe), never on a derived clock.

Parameters:
POS_W, 16, width of position outputs
SPD_W, 8, width of internal/output speed
TICK_PER_LIGHT, 10, ticks per countdown light step
ACCEL, 4, speed added per key tap
DRAG, 1, speed removed per tick
MAX_SPEED, 63, speed ceiling (must be below 2**SPD_W)
TRACK_LEN, 4000, finish position (must be below 2**POS_W)

Ports:
clk  in  1  pixel clock (65 MHz)
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle movement/timing enable, synchronous to clk
key_start  in  1  start key level
key_p1  in  1  player-1 throttle key level
key_p2  in  1  player-2 throttle key level
pos_p1  out  POS_W  player-1 track position
pos_p2  out  POS_W  player-2 track position
speed_p1  out  SPD_W  player-1 speed
speed_p2  out  SPD_W  player-2 speed
lights  out  2  countdown lights lit (0–3)
go  out  1  high while in RACE
state  out  2  00 IDLE, 01 COUNTDOWN, 10 RACE, 11 FINISH
winner  out  2  00 none, 01 p1, 10 p2, 11 tie

Behaviour:
- The single clock is clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, pos=0, speed=0, lights=0, go=0, winner=00, edge registers=0, tick counter=0.
- Edge detection: each key input has its own registered previous value. A tap is a rising edge (cur & ~prev).
  - Holding a key down yields exactly one tap.
  - The key is usable as a tap one cycle after the level rises.
- IDLE:
  - Start tap -> COUNTDOWN.
  - On entry: pos/speed cleared, lights=1, tick counter=0, winner=00.
- COUNTDOWN:
  - Each tick increments the tick counter.
  - When the counter reaches TICK_PER_LIGHT-1 on a tick: counter=0, and
    - if lights<3, lights++;
    - if lights==3, go to RACE with lights=0 and go=1.
  - Player keys are ignored here (but see FALSE_START_EN).
  - Start taps are ignored here.
- RACE, per player, in a cycle with tap a and tick t:
  - pos_next = min(pos + speed_old, TRACK_LEN) if t, else pos. Position always uses the pre-update speed.
  - speed_next = clamp(speed_old + (a ? ACCEL : 0) − (t ? DRAG : 0), 0, MAX_SPEED).
  - Compute the sum one bit wider so it cannot wrap. Saturation is applied to the signed result in one step.
  - When any pos_next == TRACK_LEN: winner = 01/10, or 11 if both reach it in the same cycle. Then state=FINISH, go=0, speed=0.
- FINISH:
  - pos and winner hold.
  - Start tap -> COUNTDOWN with the same entry actions as from IDLE.
- Start taps are ignored in RACE.
- Reset asserted mid-operation returns immediately to the reset values.
- Release of reset has no tap side effect: a key already held at reset release does not produce a tap.

Optional Feature:
Macro: RACE_CTL_FALSE_START_EN
- Defined:
  - A player tap during COUNTDOWN is a false start: winner = the other player (01/10), state=FINISH, lights=0.
  - Simultaneous false starts by both players -> winner=11.
- Undefined: player taps in COUNTDOWN are ignored, and no logic for false-start detection is generated.

Decomposition:
- Shared package race_pkg holds:
  - state encodings IDLE/COUNTDOWN/RACE/FINISH;
  - winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_TIE;
  - default POS_W, SPD_W and TRACK_LEN constants, for reuse by the draw stages.
- Sub-module race_player holds one player's edge detector plus speed/position update.
  - Inputs: clk, reset, tick, key, run, clear.
  - Outputs: pos, speed, tap, at_finish.
  - Instantiated twice; the FSM and winner logic stay in race_ctl.

Test Plan:
1. Reset then start tap, with TICK_PER_LIGHT=10 -> lights=1 immediately; 2 after 10 ticks; 3 after 20; state=RACE, go=1, lights=0 after 30 ticks.
2. In RACE, 3 p1 taps then 1 tick -> speed_p1 = 12 before the tick; after the tick pos_p1=12 and speed_p1=11. p2 stays pos=0, speed=0.
3. 20 p1 taps with no tick -> speed_p1 saturates at 63. A tap and a tick in the same cycle at speed 0 -> speed=3 and pos unchanged.
4. TRACK_LEN=100, p1 speed 63, two ticks -> pos_p1 = 63, then 100 (saturated). winner=01, state=FINISH. Later p2 taps do not change winner.
5. Both players at pos 90 with speed 10 on the same tick -> both pos=100, winner=11. Then a start tap -> COUNTDOWN with pos cleared and winner=00.
6. With RACE_CTL_FALSE_START_EN, a p2 tap at lights=2 -> winner=01, FINISH. Without the macro -> ignored, and the race starts normally.
